fifo_write_arbiter: RTL and testbench

// Shares the single write port of the FIFO between NUM_REQ requesters. Round-robin

---
 rtl/fifo_write_arbiter_pkg.sv | 9 +
 rtl/rr_priority_picker.sv | 33 +++
 rtl/fifo_write_arbiter.sv | 95 +++++++++
 tb/tb_fifo_write_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encodings and the
// default word/address widths used by the FIFO and its arbiter.
package fifo_write_arbiter_pkg;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADD_WIDTH  = 4;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first valid requester scanning upward
// from the one after last_grant, wrapping at NUM_REQ.
module rr_priority_picker
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [REQ_IDX_W-1:0] last_grant,
  output logic                 any_valid,
  output logic [REQ_IDX_W-1:0] winner
);

  logic found;
  int   idx;

  assign any_valid = |req_valid;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx[REQ_IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ requesters,
// with bounded bursts, per-requester valid/ready and stall on FIFO almost-full.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  localparam int REQ_IDX_W = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                          clk,
  input  logic                          a_Reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          Wr_enable,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [REQ_IDX_W-1:0]          grant_id,
  output logic                          busy
);

  // Handshake: requester i's word moves when req_valid[i] & req_ready[i] on a
  // rising clk edge; requesters hold data stable while valid & ~ready.

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  logic                  state;
  logic [CNT_W-1:0]      burst_cnt;
  logic [REQ_IDX_W-1:0]  last_grant;
  logic                  any_valid;
  logic [REQ_IDX_W-1:0]  winner;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] grant_word;

  rr_priority_picker #(
    .NUM_REQ   (NUM_REQ),
    .REQ_IDX_W (REQ_IDX_W)
  ) u_picker (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .any_valid  (any_valid),
    .winner     (winner)
  );

  // fifo_full is an almost-full flag, so it alone gates ready
  always_comb begin
    req_ready = '0;
    if (state == ST_BURST && !fifo_full)
      req_ready[grant_id] = 1'b1;
  end

  assign xfer       = req_valid[grant_id] & req_ready[grant_id];
  assign grant_word = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign busy       = (state == ST_BURST);

  always_ff @(posedge clk or negedge a_Reset_n) begin
    if (!a_Reset_n) begin
      state      <= ST_IDLE;
      burst_cnt  <= '0;
      grant_id   <= '0;
      last_grant <= REQ_IDX_W'(NUM_REQ - 1);
      Wr_enable  <= 1'b0;
      wr_data    <= '0;
    end else begin
      Wr_enable <= xfer;
      if (xfer)
        wr_data <= grant_word;

      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant_id  <= winner;
            burst_cnt <= '0;
            state     <= ST_BURST;
          end
        end
        default: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
            if (burst_cnt == LAST_CNT) begin
              last_grant <= grant_id;
              state      <= ST_IDLE;
            end
          end else if (!req_valid[grant_id]) begin
            last_grant <= grant_id;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, single requester, full
// rotation, fifo_full stall, wrap-around and reset mid-burst.
module tb_fifo_write_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          a_Reset_n;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          fifo_full;
  logic          Wr_enable;
  logic [DW-1:0] wr_data;
  logic [1:0]    grant_id;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int writes = 0;

  fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4)) dut (
    .clk       (clk),
    .a_Reset_n (a_Reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .Wr_enable (Wr_enable),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  initial begin
    a_Reset_n = 1'b0;
    fifo_full = 1'b0;
    req_valid = 4'hF;
    req_data  = '0;
    for (int i = 0; i < NR; i++) set_word(i, 8'h10 + 8'(i));

    // 1: reset held with every requester valid
    tick(); tick();
    chk("rst_wr_en", 32'(Wr_enable), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    a_Reset_n = 1'b1;

    // 3: continuous contention, bursts of 4 with one bubble each
    for (int t = 0; t < 20; t++) begin
      tick();
      if (Wr_enable) writes++;
      if (t % 5 == 0) begin
        chk($sformatf("rot_grant_t%0d", t), 32'(grant_id), 32'(t / 5));
        chk($sformatf("rot_busy_t%0d", t), 32'(busy), 32'd1);
        chk($sformatf("rot_bubble_t%0d", t), 32'(Wr_enable), 32'd0);
      end else begin
        chk($sformatf("rot_wr_en_t%0d", t), 32'(Wr_enable), 32'd1);
        chk($sformatf("rot_data_t%0d", t), 32'(wr_data), 32'h10 + 32'(t / 5));
      end
    end
    chk("rot_write_count", 32'(writes), 32'd16);
    tick();
    chk("rot_fifth_grant", 32'(grant_id), 32'd0);
    chk("rot_fifth_busy", 32'(busy), 32'd1);

    // 2: single requester sends 19 then 20
    a_Reset_n = 1'b0;
    req_valid = 4'b0000;
    tick();
    a_Reset_n = 1'b1;
    set_word(0, 8'd19);
    req_valid = 4'b0001;
    tick();
    chk("single_grant", 32'(grant_id), 32'd0);
    chk("single_ready", 32'(req_ready), 32'b0001);
    chk("single_no_wr_idle", 32'(Wr_enable), 32'd0);
    tick();
    set_word(0, 8'd20);
    chk("single_wr1_en", 32'(Wr_enable), 32'd1);
    chk("single_wr1_data", 32'(wr_data), 32'd19);
    tick();
    req_valid = 4'b0000;
    chk("single_wr2_en", 32'(Wr_enable), 32'd1);
    chk("single_wr2_data", 32'(wr_data), 32'd20);
    tick();
    chk("single_end_wr_en", 32'(Wr_enable), 32'd0);
    chk("single_data_hold", 32'(wr_data), 32'd20);
    chk("single_end_idle", 32'(busy), 32'd0);
    // last_grant is now 0, so requester 1 wins over requester 0
    set_word(0, 8'h10);
    set_word(1, 8'h21);
    req_valid = 4'b0011;
    tick();
    chk("last_grant0_next", 32'(grant_id), 32'd1);
    chk("g1_ready", 32'(req_ready), 32'b0010);

    // 4: fifo_full stalls after word 2
    tick();
    tick();
    chk("stall_pre_wr", 32'(Wr_enable), 32'd1);
    fifo_full = 1'b1;
    #1;
    chk("stall_ready_now", 32'(req_ready), 32'd0);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk($sformatf("stall_wr_en_%0d", t), 32'(Wr_enable), 32'd0);
      chk($sformatf("stall_ready_%0d", t), 32'(req_ready), 32'd0);
      chk($sformatf("stall_busy_%0d", t), 32'(busy), 32'd1);
    end
    fifo_full = 1'b0;
    #1;
    chk("resume_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("resume_wr3_en", 32'(Wr_enable), 32'd1);
    chk("resume_wr3_data", 32'(wr_data), 32'h21);
    tick();
    chk("resume_wr4_en", 32'(Wr_enable), 32'd1);
    chk("resume_end_busy", 32'(busy), 32'd0);
    tick();
    chk("rotate_after_stall", 32'(grant_id), 32'd0);
    chk("rotate_no_wr", 32'(Wr_enable), 32'd0);

    // 5: make requester 3 the last grant, then only requester 2 valid
    req_valid = 4'b1000;
    tick();
    chk("r0_drop_idle", 32'(busy), 32'd0);
    tick();
    chk("grant3", 32'(grant_id), 32'd3);
    set_word(3, 8'h43);
    tick();
    chk("g3_wr_data", 32'(wr_data), 32'h43);
    set_word(2, 8'h32);
    req_valid = 4'b0100;
    tick();
    chk("g3_end_idle", 32'(busy), 32'd0);
    tick();
    chk("wrap_grant2", 32'(grant_id), 32'd2);
    chk("wrap_busy", 32'(busy), 32'd1);

    // 6: reset pulse while a write strobe is high
    tick();
    chk("mid_wr_en", 32'(Wr_enable), 32'd1);
    a_Reset_n = 1'b0;
    #1;
    chk("async_wr_en", 32'(Wr_enable), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_grant", 32'(grant_id), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b0101;
    tick();
    chk("held_wr_en", 32'(Wr_enable), 32'd0);
    a_Reset_n = 1'b1;
    tick();
    chk("post_rst_grant", 32'(grant_id), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd1);
    chk("post_rst_no_wr", 32'(Wr_enable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
